// File: rtl/sample_sequencer.sv
// sample_sequencer: buffers signed 8-bit samples and replays them cycle-exactly to the
// averaging/min-max processor. Define SEQ_LFSR_EN to source STREAM data from an 8-bit LFSR.
module sample_sequencer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       WR_EN,
  input  logic [7:0] WR_DATA,
  input  logic       START,
  input  logic       AVG_MODE,
  output logic [7:0] DATA_IN,
  output logic       ENABLE,
  output logic       AVERAGE,
  output logic       RESTART,
  output logic       BUSY,
  output logic       DONE,
  output logic       FULL
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(FLUSH_CYCLES + 2);

  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [PW-1:0] WARM_LAST  = PW'(1);
  localparam logic [PW-1:0] FLUSH_LAST = PW'(FLUSH_CYCLES - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WARM   = 3'd1;
  localparam logic [2:0] STREAM = 3'd2;
  localparam logic [2:0] FLUSH  = 3'd3;
  localparam logic [2:0] RST    = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;

  logic [7:0] data_q, data_d;
  logic       enable_q, enable_d;
  logic       avg_q, avg_d;
  logic       restart_q, restart_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       full_q, full_d;

  logic       wr_acc;
  logic [7:0] stream_data;

  assign wr_acc = (state_q == IDLE) && WR_EN && (count_q != DEPTH_C);

  // Phase counter is shared by WARM and FLUSH; it restarts on every state entry.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      IDLE: begin
        if (START && (count_q != '0)) begin
          state_d = WARM;
          phase_d = '0;
        end
      end
      WARM: begin
        if (phase_q == WARM_LAST) begin
          state_d = STREAM;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      STREAM: begin
        if (rd_ptr_q == count_q) begin
          state_d = FLUSH;
          phase_d = '0;
        end
      end
      FLUSH: begin
        if (phase_q == FLUSH_LAST) begin
          state_d = RST;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      RST:     state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      count_d  = count_q + 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (state_d == STREAM) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (state_d == FIN) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

`ifdef SEQ_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       unused_wr;

  assign unused_wr   = ^{WR_DATA, wr_ptr_q, rd_ptr_q[AW-1:0]};
  assign stream_data = lfsr_q;

  always_comb begin
    lfsr_d = lfsr_q;
    if (state_d == STREAM) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  logic [7:0] mem [DEPTH];

  assign stream_data = mem[rd_ptr_q[AW-1:0]];

  // Storage carries no reset: an emptied buffer is defined by count, not contents.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= WR_DATA;
    end
  end
`endif

  // Outputs are computed from the next state so they line up with state_q cycle for cycle.
  always_comb begin
    enable_d  = (state_d == STREAM);
    data_d    = enable_d ? stream_data : '0;
    restart_d = (state_d == RST);
    done_d    = (state_d == FIN);
    busy_d    = (state_d != IDLE);
    full_d    = (count_d == DEPTH_C);
    avg_d     = '0;
    if (state_d != IDLE) begin
      avg_d = (state_q == IDLE) ? AVG_MODE : avg_q;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      data_q    <= '0;
      enable_q  <= 1'b0;
      avg_q     <= 1'b0;
      restart_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      data_q    <= data_d;
      enable_q  <= enable_d;
      avg_q     <= avg_d;
      restart_q <= restart_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      full_q    <= full_d;
    end
  end

  assign DATA_IN = data_q;
  assign ENABLE  = enable_q;
  assign AVERAGE = avg_q;
  assign RESTART = restart_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign FULL    = full_q;

endmodule
